// File: rtl/fw_wishbone_initiator_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fw_wishbone_initiator_bridge
// Description : Converts a valid/ready request/response stream into classic
//               Wishbone initiator cycles. It handles one outstanding transfer
//               at a time and does not pipeline or burst.
//
// Ports       : clock, reset        - single clock, synchronous active-high reset
//               req_valid/req_ready - request handshake (ready only in IDLE)
//               req_adr/we/sel/dat  - request address, direction, byte enables, data
//               rsp_valid/rsp_ready - response handshake
//               rsp_dat, rsp_err    - read data (0 for writes), error flag
//               i_*                 - Wishbone initiator port
//                                     (adr, dat_w, dat_r, cyc, err, sel, stb, ack, we)
//
// Build macro : FW_WB_BRIDGE_TIMEOUT_EN - enables a bus watchdog that abandons
//               a cycle after TIMEOUT cycles without ack/err (TIMEOUT >= 2).
//               Without it, BUS waits indefinitely and TIMEOUT is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fw_wishbone_initiator_bridge #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int TIMEOUT   = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    // request stream
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADR_WIDTH-1:0]   req_adr,
    input  logic                   req_we,
    input  logic [DAT_WIDTH/8-1:0] req_sel,
    input  logic [DAT_WIDTH-1:0]   req_dat,
    // response stream
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DAT_WIDTH-1:0]   rsp_dat,
    output logic                   rsp_err,
    // Wishbone initiator port
    output logic [ADR_WIDTH-1:0]   i_adr,
    output logic [DAT_WIDTH-1:0]   i_dat_w,
    input  logic [DAT_WIDTH-1:0]   i_dat_r,
    output logic                   i_cyc,
    input  logic                   i_err,
    output logic [DAT_WIDTH/8-1:0] i_sel,
    output logic                   i_stb,
    input  logic                   i_ack,
    output logic                   i_we
);

    localparam int c_SEL_WIDTH = DAT_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [DAT_WIDTH-1:0]   r_rsp_dat;
    logic                   r_rsp_err;
    logic [ADR_WIDTH-1:0]   r_adr;
    logic [DAT_WIDTH-1:0]   r_dat_w;
    logic [c_SEL_WIDTH-1:0] r_sel;
    logic                   r_cyc;
    logic                   r_stb;
    logic                   r_we;

    // Either termination ends the cycle; ERR wins when both arrive together.
    logic w_term;
    assign w_term = i_ack | i_err;

`ifdef FW_WB_BRIDGE_TIMEOUT_EN
    localparam int                    c_CNT_WIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_WIDTH-1:0] c_WAIT_LAST = c_CNT_WIDTH'(TIMEOUT - 1);

    // Counts BUS cycles without termination; cleared on every entry to BUS.
    logic [c_CNT_WIDTH-1:0] r_wait_cnt;
`else
    // TIMEOUT has no effect in this build; this empty block only references it.
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_adr       <= '0;
            r_dat_w     <= '0;
            r_sel       <= '0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
`ifdef FW_WB_BRIDGE_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_adr       <= req_adr;
                        r_we        <= req_we;
                        r_sel       <= req_sel;
                        r_dat_w     <= req_dat;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_BUS;
`ifdef FW_WB_BRIDGE_TIMEOUT_EN
                        r_wait_cnt  <= '0;
`endif
                    end
                end

                ST_BUS: begin
                    // Termination is checked first so it beats a same-edge timeout.
                    if (w_term) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_dat   <= r_we ? '0 : i_dat_r;
                        r_rsp_err   <= i_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
`ifdef FW_WB_BRIDGE_TIMEOUT_EN
                    else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + c_CNT_WIDTH'(1);
                    end
`endif
                end

                ST_RSP: begin
                    // req_ready only returns at this edge, so a new request can
                    // never be taken in the same cycle the response is consumed.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_cyc       <= 1'b0;
                    r_stb       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign i_adr     = r_adr;
    assign i_dat_w   = r_dat_w;
    assign i_sel     = r_sel;
    assign i_cyc     = r_cyc;
    assign i_stb     = r_stb;
    assign i_we      = r_we;

endmodule
`default_nettype wire

// File: tb/tb_fw_wishbone_initiator_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fw_wishbone_initiator_bridge
// Description : Directed self-checking bench for fw_wishbone_initiator_bridge
//               with a small Wishbone target model (byte-enabled memory,
//               programmable wait states, error address, never-ack mode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fw_wishbone_initiator_bridge;

    localparam int c_AW = 32;
    localparam int c_DW = 32;
    localparam int c_SW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [c_AW-1:0] req_adr;
    logic            req_we;
    logic [c_SW-1:0] req_sel;
    logic [c_DW-1:0] req_dat;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [c_DW-1:0] rsp_dat;
    logic            rsp_err;
    logic [c_AW-1:0] i_adr;
    logic [c_DW-1:0] i_dat_w;
    logic [c_DW-1:0] i_dat_r;
    logic            i_cyc;
    logic            i_err;
    logic [c_SW-1:0] i_sel;
    logic            i_stb;
    logic            i_ack;
    logic            i_we;

    fw_wishbone_initiator_bridge #(
        .ADR_WIDTH (c_AW),
        .DAT_WIDTH (c_DW),
        .TIMEOUT   (8)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_adr   (req_adr),
        .req_we    (req_we),
        .req_sel   (req_sel),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .i_adr     (i_adr),
        .i_dat_w   (i_dat_w),
        .i_dat_r   (i_dat_r),
        .i_cyc     (i_cyc),
        .i_err     (i_err),
        .i_sel     (i_sel),
        .i_stb     (i_stb),
        .i_ack     (i_ack),
        .i_we      (i_we)
    );

    always #5 clock = ~clock;

    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // ------------------------------------------------------------------ checks
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ------------------------------------------------------------ target model
    logic [31:0] mem [logic [29:0]];
    int          ack_delay    = 0;
    bit          never_ack    = 1'b0;
    bit          err_on_match = 1'b0;
    bit          err_with_ack = 1'b0;
    bit          spurious     = 1'b0;
    logic [31:0] err_adr      = 32'h2000_0000;
    logic [31:0] obs_adr, obs_dat;
    logic [3:0]  obs_sel;
    logic        obs_we;

    initial begin
        int          wait_cnt;
        logic [31:0] word;
        i_ack    = 1'b0;
        i_err    = 1'b0;
        i_dat_r  = 32'hCAFE_0001;
        wait_cnt = 0;
        obs_adr  = '0;
        obs_dat  = '0;
        obs_sel  = '0;
        obs_we   = 1'b0;
        forever begin
            @(negedge clock);
            i_ack   = spurious;
            i_err   = 1'b0;
            i_dat_r = 32'hCAFE_0001;
            if (i_cyc && i_stb && !never_ack) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    obs_adr  = i_adr;
                    obs_dat  = i_dat_w;
                    obs_sel  = i_sel;
                    obs_we   = i_we;
                    if (err_on_match && i_adr == err_adr) begin
                        i_err   = 1'b1;
                        i_ack   = err_with_ack;
                        i_dat_r = 32'hDEAD_BEEF;
                    end else begin
                        i_ack = 1'b1;
                        word  = mem.exists(i_adr[31:2]) ? mem[i_adr[31:2]] : 32'h0;
                        if (i_we) begin
                            for (int b = 0; b < 4; b++)
                                if (i_sel[b]) word[8*b +: 8] = i_dat_w[8*b +: 8];
                            mem[i_adr[31:2]] = word;
                            i_dat_r = 32'h5555_AAAA;
                        end else begin
                            i_dat_r = word;
                        end
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, output logic [31:0] rdat,
                        output logic rerr, output int acc_edge, output int rsp_edge);
        int n;
        @(negedge clock);
        req_valid = 1'b1;
        req_adr   = adr;
        req_we    = we;
        req_sel   = sel;
        req_dat   = dat;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("req_ready_wait_expired", 1'b1, 1'b0);
        @(posedge clock);
        #1;
        acc_edge  = cyc_cnt;
        req_valid = 1'b0;
        n = 0;
        @(negedge clock);
        while (!rsp_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check("rsp_valid_wait_expired", 1'b1, 1'b0);
        rsp_edge = cyc_cnt;
        rdat     = rsp_dat;
        rerr     = rsp_err;
        if (rsp_ready) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          a0, r0, n;
        int          acc [3];
        bit          bad;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_adr   = '0;
        req_we    = 1'b0;
        req_sel   = '0;
        req_dat   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst_cyc",       i_cyc,     1'b0);
        check("rst_stb",       i_stb,     1'b0);
        check("rst_we",        i_we,      1'b0);
        check("rst_adr",       i_adr,     32'h0);
        check("rst_dat_w",     i_dat_w,   32'h0);
        check("rst_sel",       i_sel,     4'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_dat",   rsp_dat,   32'h0);
        check("rst_rsp_err",   rsp_err,   1'b0);
        check("rst_req_ready", req_ready, 1'b1);

        // 1: full-word write
        xfer(32'h1000_0010, 1'b1, 4'hF, 32'hA5A5_1234, rd, er, a0, r0);
        check("wr_rsp_err", er,      1'b0);
        check("wr_rsp_dat", rd,      32'h0);
        check("wr_bus_we",  obs_we,  1'b1);
        check("wr_bus_adr", obs_adr, 32'h1000_0010);
        check("wr_bus_sel", obs_sel, 4'hF);
        check("wr_bus_dat", obs_dat, 32'hA5A5_1234);

        // 2: read back, byte-lane write, read again
        xfer(32'h1000_0010, 1'b0, 4'hF, 32'h0, rd, er, a0, r0);
        check("rd1_dat", rd, 32'hA5A5_1234);
        check("rd1_err", er, 1'b0);
        xfer(32'h1000_0010, 1'b1, 4'h2, 32'h0000_FF00, rd, er, a0, r0);
        check("wr2_bus_sel", obs_sel, 4'h2);
        xfer(32'h1000_0010, 1'b0, 4'hF, 32'h0, rd, er, a0, r0);
        check("rd2_dat", rd, 32'hA5A5_FF34);

        // 3: latency with zero wait states, three wait states, back-to-back rate
        ack_delay = 0;
        xfer(32'h1000_0010, 1'b0, 4'hF, 32'h0, rd, er, a0, r0);
        check("lat_0ws", r0 - a0, 1);
        ack_delay = 3;
        xfer(32'h1000_0013, 1'b0, 4'h8, 32'h0, rd, er, a0, r0);
        check("lat_3ws",     r0 - a0, 4);
        check("lat_3ws_adr", obs_adr, 32'h1000_0013);
        check("lat_3ws_dat", rd,      32'hA5A5_FF34);
        ack_delay = 0;

        @(negedge clock);
        req_valid = 1'b1;
        req_adr   = 32'h1000_0010;
        req_we    = 1'b0;
        req_sel   = 4'hF;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            if (req_ready) begin
                acc[n] = cyc_cnt + 1;
                n++;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        check("b2b_count",    n, 3);
        check("b2b_spacing1", acc[1] - acc[0], 3);
        check("b2b_spacing2", acc[2] - acc[1], 3);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("b2b_drain_expired", 1'b1, 1'b0);

        // Stray ack while idle must not produce a response
        spurious = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (rsp_valid || !req_ready || i_cyc) bad = 1'b1;
        end
        spurious = 1'b0;
        @(negedge clock);
        if (rsp_valid || !req_ready) bad = 1'b1;
        check("idle_ack_ignored", bad, 1'b0);

        // 4: target error, response held while rsp_ready is low
        err_on_match = 1'b1;
        rsp_ready    = 1'b0;
        xfer(32'h2000_0000, 1'b0, 4'hF, 32'h0, rd, er, a0, r0);
        check("err_rsp_err", er, 1'b1);
        check("err_rsp_dat", rd, 32'hDEAD_BEEF);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (!rsp_valid || !rsp_err || rsp_dat != 32'hDEAD_BEEF || req_ready || i_cyc)
                bad = 1'b1;
        end
        check("err_hold_stable", bad, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("err_consumed_valid", rsp_valid, 1'b0);
        check("err_consumed_ready", req_ready, 1'b1);
        err_with_ack = 1'b1;
        xfer(32'h2000_0000, 1'b0, 4'hF, 32'h0, rd, er, a0, r0);
        check("ackerr_rsp_err", er, 1'b1);
        check("ackerr_rsp_dat", rd, 32'hDEAD_BEEF);
        err_with_ack = 1'b0;
        err_on_match = 1'b0;

        // 5: reset during an unterminated cycle
        never_ack = 1'b1;
        @(negedge clock);
        req_valid = 1'b1;
        req_adr   = 32'h1000_0010;
        req_we    = 1'b1;
        req_sel   = 4'hF;
        req_dat   = 32'h1111_2222;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_cyc_before_reset", i_cyc, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_cyc",   i_cyc,     1'b0);
        check("mid_rst_stb",   i_stb,     1'b0);
        check("mid_rst_ready", req_ready, 1'b1);
        @(negedge clock);
        reset     = 1'b0;
        never_ack = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (rsp_valid || i_cyc) bad = 1'b1;
        end
        check("mid_rst_no_rsp", bad, 1'b0);
        xfer(32'h1000_0010, 1'b0, 4'hF, 32'h0, rd, er, a0, r0);
        check("post_rst_rd_dat", rd, 32'hA5A5_FF34);
        check("post_rst_rd_err", er, 1'b0);

        // 6: target never terminates
        never_ack = 1'b1;
        @(negedge clock);
        req_valid = 1'b1;
        req_adr   = 32'h3000_0000;
        req_we    = 1'b0;
        req_sel   = 4'hF;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clock);
        while (i_cyc && n < 150) begin
            n++;
            @(negedge clock);
        end
`ifdef FW_WB_BRIDGE_TIMEOUT_EN
        check("tmo_cyc_cycles", n,         8);
        check("tmo_rsp_valid",  rsp_valid, 1'b1);
        check("tmo_rsp_err",    rsp_err,   1'b1);
        check("tmo_rsp_dat",    rsp_dat,   32'h0);
        @(posedge clock);
        #1;
        never_ack = 1'b0;
`else
        check("no_tmo_cyc_held", n >= 100, 1'b1);
        check("no_tmo_no_rsp",   rsp_valid, 1'b0);
        never_ack = 1'b0;
        do_reset();
`endif
        @(negedge clock);
        check("final_idle_ready", req_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
